// File: rtl/snake_pkg.sv
// Shared types and constants for the snake body controller.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_MOVE = 2'd2,
    ST_DEAD = 2'd3
  } state_e;

  localparam int DefCoordW = 5;
  localparam int GridDim   = 1 << DefCoordW;

  // UP/DOWN and RIGHT/LEFT differ only in bit 1 of the encoding.
  function automatic dir_e opposite_dir(input dir_e d);
    return dir_e'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_body_ctrl_seg_reg.sv
// One body-segment register: parallel load with a synchronous re-init value.
module seg_reg
  import snake_pkg::*;
#(
  parameter int                    DataSize = 2 * DefCoordW,
  parameter logic [DataSize-1:0]   ResetVal = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init,
  input  logic                load,
  input  logic [DataSize-1:0] d,
  output logic [DataSize-1:0] q
);

  logic [DataSize-1:0] val_d;
  logic [DataSize-1:0] val_q;

  // Re-init wins over a shift so that start aborts any pending move.
  always_comb begin
    val_d = val_q;
    if (init) begin
      val_d = ResetVal;
    end else if (load) begin
      val_d = d;
    end
  end

  // Segment storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= ResetVal;
    end else begin
      val_q <= val_d;
    end
  end

  assign q = val_q;

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake body sequencer: per tick, compute next head, scan body for
// self-collision one segment per cycle, then shift the body or die.
module snake_body_ctrl
  import snake_pkg::*;
#(
  parameter int MaxLen  = 16,
  parameter int CoordW  = DefCoordW,
  parameter int InitLen = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      tick,
  input  logic [1:0]                dir,
  input  logic                      grow,
  input  logic [$clog2(MaxLen)-1:0] rd_idx,
  output logic [CoordW-1:0]         rd_x,
  output logic [CoordW-1:0]         rd_y,
  output logic                      rd_live,
  output logic [CoordW-1:0]         head_x,
  output logic [CoordW-1:0]         head_y,
  output logic [$clog2(MaxLen):0]   length,
  output logic                      busy,
  output logic                      dead,
  output logic                      overrun
);

  localparam int IdxW = $clog2(MaxLen);
  localparam int LenW = IdxW + 1;
  localparam int SegW = 2 * CoordW;
  localparam int MidI = 1 << (CoordW - 1);
  localparam logic [CoordW-1:0] Mid      = CoordW'(MidI);
  localparam logic [LenW-1:0]   MaxLenV  = LenW'(MaxLen);
  localparam logic [LenW-1:0]   InitLenV = LenW'(InitLen);

  state_e              state_d, state_q;
  logic [LenW-1:0]     len_d, len_q;
  dir_e                dir_d, dir_q;
  dir_e                dir_nxt_d, dir_nxt_q;
  logic                grow_lat_d, grow_lat_q;
  logic [CoordW-1:0]   nhx_d, nhx_q, nhy_d, nhy_q;
  logic [IdxW-1:0]     idx_d, idx_q;
  logic                overrun_d, overrun_q;
  logic [CoordW-1:0]   rd_x_d, rd_x_q, rd_y_d, rd_y_q;
  logic                rd_live_d, rd_live_q;

  logic [SegW-1:0]     seg_q [MaxLen];
  logic [SegW-1:0]     seg_d [MaxLen];
  logic                shift;
  dir_e                eff_dir;
  logic [CoordW-1:0]   step_x, step_y;
  logic [LenW-1:0]     scan_last;

  // Segment bank: segment 0 takes the registered next head, the rest chain.
  for (genvar k = 0; k < MaxLen; k++) begin : g_seg
    localparam logic [CoordW-1:0] XInit  = CoordW'(MidI - k);
    localparam logic [SegW-1:0]   RstVal = (k < InitLen) ? {XInit, Mid} : '0;
    if (k == 0) begin : g_head
      assign seg_d[k] = {nhx_q, nhy_q};
    end else begin : g_body
      assign seg_d[k] = seg_q[k-1];
    end
    seg_reg #(.DataSize(SegW), .ResetVal(RstVal)) u_seg (
      .clk   (clk),
      .rst_n (rst_n),
      .init  (start),
      .load  (shift),
      .d     (seg_d[k]),
      .q     (seg_q[k])
    );
  end

  assign head_x = seg_q[0][SegW-1:CoordW];
  assign head_y = seg_q[0][CoordW-1:0];

  // Effective direction (reversal ignored) and the wrapped next head.
  always_comb begin
    eff_dir = dir_e'(dir);
    if (eff_dir == opposite_dir(dir_q)) begin
      eff_dir = dir_q;
    end
    step_x = head_x;
    step_y = head_y;
    case (eff_dir)
      DIR_UP:    step_y = head_y - 1'b1;
      DIR_RIGHT: step_x = head_x + 1'b1;
      DIR_DOWN:  step_y = head_y + 1'b1;
      default:   step_x = head_x - 1'b1;
    endcase
  end

  // Last index to scan: the tail cell only counts when the snake grows.
  assign scan_last = (grow_lat_q ? len_q : len_q - 1'b1) - 1'b1;

  // Step sequencer: next state, counters and sticky flags.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    dir_d      = dir_q;
    dir_nxt_d  = dir_nxt_q;
    grow_lat_d = grow_lat_q;
    nhx_d      = nhx_q;
    nhy_d      = nhy_q;
    idx_d      = idx_q;
    overrun_d  = overrun_q;
    shift      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          grow_lat_d = grow;
          dir_nxt_d  = eff_dir;
          nhx_d      = step_x;
          nhy_d      = step_y;
          idx_d      = '0;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (seg_q[idx_q] == {nhx_q, nhy_q}) begin
          state_d = ST_DEAD;
        end else if ({1'b0, idx_q} == scan_last) begin
          state_d = ST_MOVE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_MOVE: begin
        shift = 1'b1;
        if (grow_lat_q && (len_q < MaxLenV)) begin
          len_d = len_q + 1'b1;
        end
        dir_d   = dir_nxt_q;
        state_d = ST_IDLE;
      end
      default: begin
      end
    endcase
    if (tick && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end
    if (start) begin
      state_d    = ST_IDLE;
      len_d      = InitLenV;
      dir_d      = DIR_RIGHT;
      dir_nxt_d  = DIR_RIGHT;
      grow_lat_d = 1'b0;
      nhx_d      = '0;
      nhy_d      = '0;
      idx_d      = '0;
      overrun_d  = 1'b0;
      shift      = 1'b0;
    end
  end

  // Registered read port; sees pre-shift contents during MOVE.
  always_comb begin
    rd_x_d    = seg_q[rd_idx][SegW-1:CoordW];
    rd_y_d    = seg_q[rd_idx][CoordW-1:0];
    rd_live_d = ({1'b0, rd_idx} < len_q);
    if (start) begin
      rd_x_d    = '0;
      rd_y_d    = '0;
      rd_live_d = 1'b0;
    end
  end

  // Control and read-port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= InitLenV;
      dir_q      <= DIR_RIGHT;
      dir_nxt_q  <= DIR_RIGHT;
      grow_lat_q <= 1'b0;
      nhx_q      <= '0;
      nhy_q      <= '0;
      idx_q      <= '0;
      overrun_q  <= 1'b0;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      rd_live_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      dir_q      <= dir_d;
      dir_nxt_q  <= dir_nxt_d;
      grow_lat_q <= grow_lat_d;
      nhx_q      <= nhx_d;
      nhy_q      <= nhy_d;
      idx_q      <= idx_d;
      overrun_q  <= overrun_d;
      rd_x_q     <= rd_x_d;
      rd_y_q     <= rd_y_d;
      rd_live_q  <= rd_live_d;
    end
  end

  assign rd_x    = rd_x_q;
  assign rd_y    = rd_y_q;
  assign rd_live = rd_live_q;
  assign length  = len_q;
  assign busy    = (state_q == ST_SCAN) || (state_q == ST_MOVE);
  assign dead    = (state_q == ST_DEAD);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Directed bench for snake_body_ctrl (MaxLen 16, CoordW 5, InitLen 3).
module tb_snake_body_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] dir = 2'd1;
  logic       grow = 1'b0;
  logic [3:0] rd_idx = 4'd0;
  logic [4:0] rd_x, rd_y, head_x, head_y;
  logic       rd_live, busy, dead, overrun;
  logic [4:0] length;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  localparam logic [1:0] UP = 2'd0, RIGHT = 2'd1, DOWN = 2'd2, LEFT = 2'd3;

  snake_body_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .tick    (tick),
    .dir     (dir),
    .grow    (grow),
    .rd_idx  (rd_idx),
    .rd_x    (rd_x),
    .rd_y    (rd_y),
    .rd_live (rd_live),
    .head_x  (head_x),
    .head_y  (head_y),
    .length  (length),
    .busy    (busy),
    .dead    (dead),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one tick, then count the cycles busy stays high (bounded).
  task automatic step(input logic [1:0] d, input logic g, output int cnt);
    dir  = d;
    grow = g;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    grow = 1'b0;
    cnt  = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) return;
      cnt++;
      @(negedge clk);
    end
    check("step_timeout", 32'(cnt), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd_check(input string tag, input logic [3:0] i,
                          input int ex, input int ey, input logic el);
    rd_idx = i;
    @(negedge clk);
    check({tag, "_x"}, 32'(rd_x), 32'(ex));
    check({tag, "_y"}, 32'(rd_y), 32'(ey));
    check({tag, "_live"}, 32'(rd_live), 32'(el));
  endtask

  // 2x2 loop: after this the tail (16,16) is directly above the head (16,17).
  task automatic setup_square();
    int c;
    pulse_start();
    step(RIGHT, 1'b1, c);
    step(DOWN, 1'b0, c);
    step(LEFT, 1'b0, c);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_len", 32'(length), 32'd3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dead", 32'(dead), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_rdx", 32'(rd_x), 32'd0);
    check("rst_rdlive", 32'(rd_live), 32'd0);
    check("rst_head_x", 32'(head_x), 32'd16);
    check("rst_head_y", 32'(head_y), 32'd16);
    rst_n = 1'b1;
    @(negedge clk);

    // Initial body readback
    rd_check("rd0", 4'd0, 16, 16, 1'b1);
    rd_check("rd1", 4'd1, 15, 16, 1'b1);
    rd_check("rd2", 4'd2, 14, 16, 1'b1);
    rd_check("rd3", 4'd3, 0, 0, 1'b0);

    // Turn UP from reset
    step(UP, 1'b0, cyc);
    check("up_busy", 32'(cyc), 32'd3);
    check("up_head_x", 32'(head_x), 32'd16);
    check("up_head_y", 32'(head_y), 32'd15);
    check("up_len", 32'(length), 32'd3);
    rd_check("up_seg1", 4'd1, 16, 16, 1'b1);

    // Start restores reset body; reversal LEFT while moving RIGHT is ignored
    pulse_start();
    check("start_head_y", 32'(head_y), 32'd16);
    step(LEFT, 1'b0, cyc);
    check("rev_head_x", 32'(head_x), 32'd17);
    check("rev_head_y", 32'(head_y), 32'd16);
    check("rev_dead", 32'(dead), 32'd0);

    // Walk right to the edge, then wrap
    for (int i = 0; i < 14; i++) step(RIGHT, 1'b0, cyc);
    check("edge_head_x", 32'(head_x), 32'd31);
    step(RIGHT, 1'b0, cyc);
    check("wrap_head_x", 32'(head_x), 32'd0);
    check("wrap_head_y", 32'(head_y), 32'd16);
    rd_check("wrap_seg1", 4'd1, 31, 16, 1'b1);

    // Move into the vacating tail: legal
    setup_square();
    check("sq_len", 32'(length), 32'd4);
    check("sq_head_y", 32'(head_y), 32'd17);
    rd_check("sq_tail", 4'd3, 16, 16, 1'b1);
    step(UP, 1'b0, cyc);
    check("tail_busy", 32'(cyc), 32'd4);
    check("tail_dead", 32'(dead), 32'd0);
    check("tail_head_x", 32'(head_x), 32'd16);
    check("tail_head_y", 32'(head_y), 32'd16);

    // Same move while growing: tail stays, collision
    setup_square();
    step(UP, 1'b1, cyc);
    check("grow_col_busy", 32'(cyc), 32'd4);
    check("grow_col_dead", 32'(dead), 32'd1);
    check("grow_col_len", 32'(length), 32'd4);
    check("grow_col_head_y", 32'(head_y), 32'd17);
    step(RIGHT, 1'b0, cyc);
    check("dead_frozen_x", 32'(head_x), 32'd16);
    check("dead_tick_ovr", 32'(overrun), 32'd1);
    check("dead_still", 32'(dead), 32'd1);
    pulse_start();
    check("start_clr_dead", 32'(dead), 32'd0);
    check("start_clr_ovr", 32'(overrun), 32'd0);

    // Tick during SCAN is dropped but flagged
    dir  = RIGHT;
    tick = 1'b1;
    @(negedge clk);
    dir = UP;
    @(negedge clk);
    tick = 1'b0;
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_head_x", 32'(head_x), 32'd17);
    check("ovr_head_y", 32'(head_y), 32'd16);
    check("ovr_busy", 32'(busy), 32'd0);

    // Reset mid-step aborts with no partial shift
    dir  = RIGHT;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    rst_n = 1'b0;
    #2;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_head_x", 32'(head_x), 32'd16);
    check("arst_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_after_x", 32'(head_x), 32'd16);

    // Grow to the maximum, then grow is ignored
    for (int i = 0; i < 13; i++) step(RIGHT, 1'b1, cyc);
    check("max_len", 32'(length), 32'd16);
    check("max_head_x", 32'(head_x), 32'd29);
    step(RIGHT, 1'b1, cyc);
    check("max_busy", 32'(cyc), 32'd17);
    check("max_len_hold", 32'(length), 32'd16);
    check("max_head_x2", 32'(head_x), 32'd30);
    rd_check("max_seg15", 4'd15, 15, 16, 1'b1);

    // Start together with tick: start wins
    start = 1'b1;
    tick  = 1'b1;
    dir   = UP;
    @(negedge clk);
    start = 1'b0;
    tick  = 1'b0;
    check("st_tick_busy", 32'(busy), 32'd0);
    check("st_tick_len", 32'(length), 32'd3);
    check("st_tick_head_x", 32'(head_x), 32'd16);
    repeat (4) @(negedge clk);
    check("st_tick_head_y", 32'(head_y), 32'd16);
    check("st_tick_ovr", 32'(overrun), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
